// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add MUL
// and one-bit-per-cycle SHL, behind a start/busy/done handshake with registered flags.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       aluk,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             busy,
    output logic             done,
    output logic [2:0]       nzp,
    output logic             C,
    output logic             V
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_SUB  = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_SHL  = 3'b111
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;     // multiplicand, shifted left each MUL step
    logic [WIDTH-1:0] b_q;     // multiplier, shifted right each MUL step
    logic [WIDTH-1:0] acc_q;   // partial product (MUL) or shifted value (SHL)
    logic [SHW-1:0]   cnt_q;   // remaining iterations minus one

    op_t              op_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic [WIDTH-1:0] iter_res;

    function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] v);
        logic n;
        logic z;
        n = v[WIDTH-1];
        z = (v == '0);
        return {n, z, !n && !z};
    endfunction

    assign op_in = op_t'(aluk);
    assign shamt = B[SHW-1:0];

    // Single-cycle results come straight from the operands sampled on the accept edge.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sum    = {1'b0, A} + {1'b0, B};
        diff   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        case (op_in)
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
                sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_NOT:  sc_res = ~A;
            OP_PASS: sc_res = A;
            OP_XOR:  sc_res = A ^ B;
            OP_SHL:  sc_res = A;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        iter_res = acc_q << 1;
        if (op_q == OP_MUL) begin
            iter_res = acc_q + (b_q[0] ? a_q : '0);
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            S     <= '0;
            nzp   <= 3'b010;
            C     <= 1'b0;
            V     <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= op_in;
                        busy <= 1'b1;
                        if (op_in == OP_MUL) begin
                            acc_q <= '0;
                            cnt_q <= SHW'(WIDTH - 1);
                            state <= ITER;
                        end else if (op_in == OP_SHL && shamt != '0) begin
                            acc_q <= A;
                            cnt_q <= shamt - SHW'(1);
                            state <= ITER;
                        end else begin
                            S     <= sc_res;
                            nzp   <= flags_of(sc_res);
                            C     <= sc_c;
                            V     <= sc_v;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ITER: begin
                    acc_q <= iter_res;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        S     <= iter_res;
                        nzp   <= flags_of(iter_res);
                        C     <= 1'b0;
                        V     <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; next accept is from IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=16): latency, results,
// flags, busy/hold behaviour, ignored starts and reset abort.
module tb_alu_multicycle;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [2:0]  aluk;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] S;
    logic        busy;
    logic        done;
    logic [2:0]  nzp;
    logic        C;
    logic        V;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .aluk  (aluk),
        .A     (A),
        .B     (B),
        .S     (S),
        .busy  (busy),
        .done  (done),
        .nzp   (nzp),
        .C     (C),
        .V     (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, result, flags and handshake.
    // With hold=1, start stays high with junk operands through the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input int lat, input logic [15:0] es, input logic [2:0] enzp,
                          input logic ec, input logic ev, input bit hold);
        logic [15:0] prev_s;
        int          cycles;
        bit          busy_bad;
        bit          hold_bad;
        prev_s = S;
        start  = 1'b1;
        aluk   = op;
        A      = a;
        B      = b;
        @(posedge Clk); #1;
        start = hold;
        aluk  = hold ? 3'b000 : ~op;
        A     = a ^ 16'h5A5A;
        B     = b ^ 16'hA5A5;
        cycles   = 1;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (S !== prev_s) hold_bad = 1'b1;
            @(posedge Clk); #1;
            A = A + 16'h0101;
            B = B - 16'h0011;
            cycles++;
        end
        check({tag, " latency"}, cycles, lat);
        check({tag, " S"}, S, es);
        check({tag, " nzp"}, nzp, enzp);
        check({tag, " C"}, C, ec);
        check({tag, " V"}, V, ev);
        check({tag, " busy@done"}, busy, 1'b1);
        check({tag, " busy during op"}, busy_bad, 1'b0);
        check({tag, " S held during op"}, hold_bad, 1'b0);
        @(posedge Clk); #1;
        check({tag, " done pulse width"}, done, 1'b0);
        check({tag, " busy after done"}, busy, 1'b0);
        start = 1'b0;
        @(posedge Clk); #1;
        check({tag, " no re-accept"}, busy, 1'b0);
    endtask

    initial begin
        int dones;
        Reset = 1'b1;
        start = 1'b1;
        aluk  = 3'b000;
        A     = 16'h0005;
        B     = 16'h0006;
        @(posedge Clk);
        @(posedge Clk); #1;
        check("reset S", S, 16'h0000);
        check("reset nzp", nzp, 3'b010);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset C", C, 1'b0);
        check("reset V", V, 1'b0);
        Reset = 1'b0;
        start = 1'b0;
        @(posedge Clk); #1;

        //     tag           op      A         B         lat S         nzp     C     V    hold
        run_op("add 3+4",    3'b000, 16'h0003, 16'h0004, 1,  16'h0007, 3'b001, 1'b0, 1'b0, 0);
        run_op("add ovf",    3'b000, 16'h7FFF, 16'h0001, 1,  16'h8000, 3'b100, 1'b0, 1'b1, 0);
        run_op("add carry",  3'b000, 16'hFFFF, 16'h0001, 1,  16'h0000, 3'b010, 1'b1, 1'b0, 0);
        run_op("sub 3-5",    3'b100, 16'h0003, 16'h0005, 1,  16'hFFFE, 3'b100, 1'b0, 1'b0, 0);
        run_op("sub 5-3",    3'b100, 16'h0005, 16'h0003, 1,  16'h0002, 3'b001, 1'b1, 1'b0, 0);
        run_op("sub ovf",    3'b100, 16'h8000, 16'h0001, 1,  16'h7FFF, 3'b001, 1'b1, 1'b1, 0);
        run_op("sub equal",  3'b100, 16'h1234, 16'h1234, 1,  16'h0000, 3'b010, 1'b1, 1'b0, 0);
        run_op("and",        3'b001, 16'hF0F0, 16'hFF00, 1,  16'hF000, 3'b100, 1'b0, 1'b0, 0);
        run_op("xor",        3'b101, 16'hF0F0, 16'hFF00, 1,  16'h0FF0, 3'b001, 1'b0, 1'b0, 0);
        run_op("not",        3'b010, 16'hF0F0, 16'hFF00, 1,  16'h0F0F, 3'b001, 1'b0, 1'b0, 0);
        run_op("pass",       3'b011, 16'hF0F0, 16'hFF00, 1,  16'hF0F0, 3'b100, 1'b0, 1'b0, 0);
        run_op("mul",        3'b110, 16'h0012, 16'h0034, 17, 16'h03A8, 3'b001, 1'b0, 1'b0, 0);
        run_op("mul wrap",   3'b110, 16'h0100, 16'h0100, 17, 16'h0000, 3'b010, 1'b0, 1'b0, 0);
        run_op("mul big",    3'b110, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 3'b001, 1'b0, 1'b0, 0);
        run_op("shl 5",      3'b111, 16'h0001, 16'h0005, 6,  16'h0020, 3'b001, 1'b0, 1'b0, 0);
        run_op("shl 0",      3'b111, 16'h1234, 16'h0000, 1,  16'h1234, 3'b001, 1'b0, 1'b0, 0);
        run_op("shl msb",    3'b111, 16'h8001, 16'h0001, 2,  16'h0002, 3'b001, 1'b0, 1'b0, 0);
        run_op("shl mask",   3'b111, 16'h0001, 16'h0013, 4,  16'h0008, 3'b001, 1'b0, 1'b0, 0);
        run_op("shl 15",     3'b111, 16'h0003, 16'h000F, 16, 16'h8000, 3'b100, 1'b0, 1'b0, 0);
        run_op("mul busy",   3'b110, 16'h0012, 16'h0034, 17, 16'h03A8, 3'b001, 1'b0, 1'b0, 1);
        run_op("add busy",   3'b000, 16'h0010, 16'h0020, 1,  16'h0030, 3'b001, 1'b0, 1'b0, 1);

        // Abort a MUL with reset sampled at edge t+5.
        start = 1'b1;
        aluk  = 3'b110;
        A     = 16'h0012;
        B     = 16'h0034;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("abort busy before reset", busy, 1'b1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort S", S, 16'h0000);
        check("abort nzp", nzp, 3'b010);
        check("abort done", done, 1'b0);
        dones = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("abort no done pulse", dones, 0);

        run_op("add after abort", 3'b000, 16'h0003, 16'h0004, 1, 16'h0007, 3'b001, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
